// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - hazard controller <-> datapath signal bundle
//
// Purpose: carries the pipeline-register tags the hazard controller inspects
// and the stage enables, flushes and forwarding selects it returns.
// Modports:
//   master - datapath side: drives register tags and controls, receives the
//            stage control.
//   slave  - controller side: the mirror of master.
// Signals:
//   id_*   IF/ID source registers and their use flags
//   ex_*   ID/EX sources, destination, memread/regwrite, branch-taken
//   mem_*  EX/MEM destination, regwrite, access flag; dmem_ready from memory
//   wb_*   MEM/WB destination and regwrite; halt_req when ecall/ebreak is in WB
//   out    pc/stage write enables, if_id_flush, id_ex_bubble, mem_wb_bubble,
//          forward_a/forward_b, halted, mem_timeout
interface pipeline_hazard_ctrl_if;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_uses_rs1;
  logic       id_uses_rs2;
  logic [4:0] ex_rs1;
  logic [4:0] ex_rs2;
  logic [4:0] ex_rd;
  logic       ex_memread;
  logic       ex_regwrite;
  logic       ex_branch_taken;
  logic [4:0] mem_rd;
  logic       mem_regwrite;
  logic       mem_access;
  logic       dmem_ready;
  logic [4:0] wb_rd;
  logic       wb_regwrite;
  logic       halt_req;

  logic       pc_write;
  logic       if_id_write;
  logic       id_ex_write;
  logic       ex_mem_write;
  logic       if_id_flush;
  logic       id_ex_bubble;
  logic       mem_wb_bubble;
  logic [1:0] forward_a;
  logic [1:0] forward_b;
  logic       halted;
  logic       mem_timeout;

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
    output ex_rs1, ex_rs2, ex_rd, ex_memread, ex_regwrite, ex_branch_taken,
    output mem_rd, mem_regwrite, mem_access, dmem_ready,
    output wb_rd, wb_regwrite, halt_req,
    input  pc_write, if_id_write, id_ex_write, ex_mem_write,
    input  if_id_flush, id_ex_bubble, mem_wb_bubble,
    input  forward_a, forward_b, halted, mem_timeout
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
    input  ex_rs1, ex_rs2, ex_rd, ex_memread, ex_regwrite, ex_branch_taken,
    input  mem_rd, mem_regwrite, mem_access, dmem_ready,
    input  wb_rd, wb_regwrite, halt_req,
    output pc_write, if_id_write, id_ex_write, ex_mem_write,
    output if_id_flush, id_ex_bubble, mem_wb_bubble,
    output forward_a, forward_b, halted, mem_timeout
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - central stall/flush/forward controller for the 5-stage pipeline
//
// Purpose: each cycle decides stage write-enables, bubbles, flushes and
// operand forwarding selects; resolves load-use hazards, taken-branch flushes
// and multi-cycle data-memory waits, and latches a halt.
// Ports:
//   clock        rising-edge clock
//   reset        asynchronous active-low reset
//   hz           pipeline_hazard_ctrl_if.slave (tags in, stage control out)
//   stall_cycles perf counter, only with HAZARD_PERF_CNT_EN
//   flush_count  perf counter, only with HAZARD_PERF_CNT_EN
// Configuration macro: HAZARD_PERF_CNT_EN adds the two saturating counters.
// Stage control is Mealy: combinational from inputs and the registered state.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  pipeline_hazard_ctrl_if.slave  hz
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]       stall_cycles,
  output logic [CNT_W-1:0]       flush_count
`endif
);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_HALTED   = 2'd2
  } state_t;

  localparam int                WAIT_W   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  state_t            state;
  state_t            next_state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              mem_timeout_q;

  logic       pc_write;
  logic       if_id_write;
  logic       id_ex_write;
  logic       ex_mem_write;
  logic       if_id_flush;
  logic       id_ex_bubble;
  logic       mem_wb_bubble;
  logic       mem_stall;
  logic       load_use;
  logic [1:0] forward_a;
  logic [1:0] forward_b;

  assign load_use = hz.ex_memread && (hz.ex_rd != 5'd0) &&
                    ((hz.id_uses_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                     (hz.id_uses_rs2 && (hz.id_rs2 == hz.ex_rd)));

  // Priority: halted > halt request (RUN only) > memory wait > taken branch
  // > load-use > normal flow. A branch beats load-use because the stalled ID
  // instruction is on the wrong path anyway.
  always_comb begin
    pc_write      = 1'b0;
    if_id_write   = 1'b0;
    id_ex_write   = 1'b0;
    ex_mem_write  = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    mem_wb_bubble = 1'b0;
    mem_stall     = 1'b0;
    next_state    = state;
    if (!reset) begin
      next_state = S_RUN;
    end else if (state == S_HALTED) begin
      next_state = S_HALTED;
    end else if ((state == S_RUN) && hz.halt_req) begin
      // The WB write of the ecall/ebreak still lands; everything else freezes.
      next_state = S_HALTED;
    end else if (hz.mem_access && !hz.dmem_ready) begin
      mem_wb_bubble = 1'b1;
      mem_stall     = 1'b1;
      next_state    = S_MEM_WAIT;
    end else begin
      // Also the MEM_WAIT exit: with dmem_ready the normal rules apply at once.
      next_state = S_RUN;
      if (hz.ex_branch_taken) begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_write  = 1'b1;
        ex_mem_write = 1'b1;
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
      end else if (load_use) begin
        id_ex_write  = 1'b1;
        ex_mem_write = 1'b1;
        id_ex_bubble = 1'b1;
      end else begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_write  = 1'b1;
        ex_mem_write = 1'b1;
      end
    end
  end

  // Forwarding ignores the FSM except for the frozen and reset cases.
  always_comb begin
    forward_a = 2'b00;
    forward_b = 2'b00;
    if (reset && (state != S_HALTED)) begin
      if (hz.mem_regwrite && (hz.mem_rd != 5'd0) && (hz.mem_rd == hz.ex_rs1))
        forward_a = 2'b10;
      else if (hz.wb_regwrite && (hz.wb_rd != 5'd0) && (hz.wb_rd == hz.ex_rs1))
        forward_a = 2'b01;
      if (hz.mem_regwrite && (hz.mem_rd != 5'd0) && (hz.mem_rd == hz.ex_rs2))
        forward_b = 2'b10;
      else if (hz.wb_regwrite && (hz.wb_rd != 5'd0) && (hz.wb_rd == hz.ex_rs2))
        forward_b = 2'b01;
    end
  end

  // wait_cnt counts consecutive memory-stall cycles, including the RUN cycle
  // that first sees the stall; any non-stall cycle restarts it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= S_RUN;
      wait_cnt      <= '0;
      mem_timeout_q <= 1'b0;
`ifdef HAZARD_PERF_CNT_EN
      stall_cycles  <= '0;
      flush_count   <= '0;
`endif
    end else begin
      state <= next_state;
      if (mem_stall) begin
        if (wait_cnt != WAIT_MAX)
          wait_cnt <= wait_cnt + 1'b1;
        if (wait_cnt == WAIT_MAX - 1'b1)
          mem_timeout_q <= 1'b1;
      end else begin
        wait_cnt <= '0;
      end
`ifdef HAZARD_PERF_CNT_EN
      if (!pc_write && (state != S_HALTED) && (stall_cycles != {CNT_W{1'b1}}))
        stall_cycles <= stall_cycles + 1'b1;
      if (if_id_flush && (flush_count != {CNT_W{1'b1}}))
        flush_count <= flush_count + 1'b1;
`endif
    end
  end

  assign hz.pc_write      = pc_write;
  assign hz.if_id_write   = if_id_write;
  assign hz.id_ex_write   = id_ex_write;
  assign hz.ex_mem_write  = ex_mem_write;
  assign hz.if_id_flush   = if_id_flush;
  assign hz.id_ex_bubble  = id_ex_bubble;
  assign hz.mem_wb_bubble = mem_wb_bubble;
  assign hz.forward_a     = forward_a;
  assign hz.forward_b     = forward_b;
  assign hz.halted        = (state == S_HALTED);
  assign hz.mem_timeout   = mem_timeout_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed and randomized checks of pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;
  localparam int MEM_TIMEOUT = 16;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  pipeline_hazard_ctrl_if hz();
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;
`endif

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(32)) dut (
    .clock(clock),
    .reset(reset),
    .hz(hz)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cycles(stall_cycles),
    .flush_count(flush_count)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // Reference model: frozen flag, "previous cycle was a memory stall" flag,
  // run length of consecutive memory stalls, sticky timeout, event tallies.
  bit     m_halted, m_waiting, m_timeout;
  int     m_wait_run;
  longint m_stall, m_flush;

  logic [3:0] e_en;   // {pc, if_id, id_ex, ex_mem}
  logic       e_flush, e_bub, e_mwb;

  function automatic logic [1:0] fwd_ref(input logic [4:0] rs);
    if (m_halted) return 2'b00;
    if (hz.mem_regwrite && hz.mem_rd != 0 && hz.mem_rd == rs) return 2'b10;
    if (hz.wb_regwrite && hz.wb_rd != 0 && hz.wb_rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic predict();
    bit lu;
    lu = hz.ex_memread && hz.ex_rd != 0 &&
         ((hz.id_uses_rs1 && hz.id_rs1 == hz.ex_rd) || (hz.id_uses_rs2 && hz.id_rs2 == hz.ex_rd));
    e_en = 4'b0000; e_flush = 0; e_bub = 0; e_mwb = 0;
    if (m_halted || (!m_waiting && hz.halt_req)) e_en = 4'b0000;
    else if (hz.mem_access && !hz.dmem_ready) e_mwb = 1;
    else if (hz.ex_branch_taken) begin e_en = 4'b1111; e_flush = 1; e_bub = 1; end
    else if (lu) begin e_en = 4'b0011; e_bub = 1; end
    else e_en = 4'b1111;
  endtask

  // Inputs are set at a negedge; compare 2 time units later, then advance the
  // model across the following posedge.
  task automatic cycle();
    #2;
    predict();
    check("enables", {hz.pc_write, hz.if_id_write, hz.id_ex_write, hz.ex_mem_write}, e_en);
    check("if_id_flush", hz.if_id_flush, e_flush);
    check("id_ex_bubble", hz.id_ex_bubble, e_bub);
    check("mem_wb_bubble", hz.mem_wb_bubble, e_mwb);
    check("forward_a", hz.forward_a, fwd_ref(hz.ex_rs1));
    check("forward_b", hz.forward_b, fwd_ref(hz.ex_rs2));
    check("halted", hz.halted, m_halted);
    check("mem_timeout", hz.mem_timeout, m_timeout);
`ifdef HAZARD_PERF_CNT_EN
    check("stall_cycles", stall_cycles, m_stall);
    check("flush_count", flush_count, m_flush);
`endif
    if (!m_halted && !e_en[3]) m_stall++;
    if (e_flush) m_flush++;
    if (e_mwb) begin
      m_wait_run++;
      if (m_wait_run >= MEM_TIMEOUT) m_timeout = 1;
    end else m_wait_run = 0;
    m_halted  = m_halted || (!m_waiting && hz.halt_req);
    m_waiting = e_mwb;
    @(negedge clock);
  endtask

  task automatic clear_inputs();
    hz.id_rs1 = 0; hz.id_rs2 = 0; hz.id_uses_rs1 = 0; hz.id_uses_rs2 = 0;
    hz.ex_rs1 = 0; hz.ex_rs2 = 0; hz.ex_rd = 0; hz.ex_memread = 0; hz.ex_regwrite = 0;
    hz.ex_branch_taken = 0; hz.mem_rd = 0; hz.mem_regwrite = 0; hz.mem_access = 0;
    hz.dmem_ready = 1; hz.wb_rd = 0; hz.wb_regwrite = 0; hz.halt_req = 0;
  endtask

  task automatic random_inputs();
    hz.id_rs1 = 5'($urandom_range(0, 3)); hz.id_rs2 = 5'($urandom_range(0, 3));
    hz.id_uses_rs1 = 1'($urandom); hz.id_uses_rs2 = 1'($urandom);
    hz.ex_rs1 = 5'($urandom_range(0, 3)); hz.ex_rs2 = 5'($urandom_range(0, 3));
    hz.ex_rd = 5'($urandom_range(0, 3)); hz.ex_memread = 1'($urandom);
    hz.ex_regwrite = 1'($urandom); hz.ex_branch_taken = ($urandom_range(0, 4) == 0);
    hz.mem_rd = 5'($urandom_range(0, 3)); hz.mem_regwrite = 1'($urandom);
    hz.mem_access = 1'($urandom); hz.dmem_ready = ($urandom_range(0, 3) != 0);
    hz.wb_rd = 5'($urandom_range(0, 3)); hz.wb_regwrite = 1'($urandom);
    hz.halt_req = ($urandom_range(0, 79) == 0);
  endtask

  // Called right after a negedge: asserts reset asynchronously, checks the
  // all-zero outputs, holds across one posedge, releases at a negedge.
  task automatic apply_reset();
    #1 reset = 1'b0;
    #1;
    check("rst_enables", {hz.pc_write, hz.if_id_write, hz.id_ex_write, hz.ex_mem_write}, 4'b0000);
    check("rst_flush_bubbles", {hz.if_id_flush, hz.id_ex_bubble, hz.mem_wb_bubble}, 3'b000);
    check("rst_forward", {hz.forward_a, hz.forward_b}, 4'b0000);
    check("rst_halted", hz.halted, 1'b0);
    check("rst_mem_timeout", hz.mem_timeout, 1'b0);
`ifdef HAZARD_PERF_CNT_EN
    check("rst_counters", {stall_cycles, flush_count}, 64'd0);
`endif
    m_halted = 0; m_waiting = 0; m_timeout = 0; m_wait_run = 0; m_stall = 0; m_flush = 0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    int halt_run;
    clear_inputs();
    @(negedge clock);
    apply_reset();

    // Load-use stall, then forward from MEM/WB.
    hz.ex_memread = 1; hz.ex_rd = 5; hz.id_rs1 = 5; hz.id_uses_rs1 = 1; hz.ex_regwrite = 1;
    #1 check("lu_stall", {hz.pc_write, hz.if_id_write, hz.id_ex_bubble}, 3'b001);
    cycle();
    clear_inputs();
    hz.wb_rd = 5; hz.ex_rs1 = 5; hz.wb_regwrite = 1;
    #1 check("lu_fwd_a", hz.forward_a, 2'b01);
    cycle();

    // EX/MEM beats MEM/WB; x0 never forwards.
    clear_inputs();
    hz.mem_rd = 7; hz.wb_rd = 7; hz.ex_rs2 = 7; hz.mem_regwrite = 1; hz.wb_regwrite = 1;
    #1 check("fwd_prio", hz.forward_b, 2'b10);
    cycle();
    hz.mem_rd = 0; hz.wb_rd = 0; hz.ex_rs2 = 0;
    #1 check("fwd_x0", hz.forward_b, 2'b00);
    cycle();

    // Taken branch with a simultaneous load-use: branch wins.
    apply_reset();
    clear_inputs();
    hz.ex_memread = 1; hz.ex_rd = 5; hz.id_rs1 = 5; hz.id_uses_rs1 = 1; hz.ex_branch_taken = 1;
    #1 check("br_lu", {hz.pc_write, hz.if_id_flush, hz.id_ex_bubble}, 3'b111);
    cycle();
`ifdef HAZARD_PERF_CNT_EN
    check("br_flush_count", flush_count, 32'd1);
`endif

    // Memory wait of 3 cycles, then resume.
    apply_reset();
    clear_inputs();
    hz.mem_access = 1; hz.dmem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1 check("mw_stall", {hz.pc_write, hz.ex_mem_write, hz.mem_wb_bubble}, 3'b001);
      cycle();
    end
    hz.dmem_ready = 1;
    #1 check("mw_resume", {hz.pc_write, hz.mem_wb_bubble}, 2'b10);
    cycle();
`ifdef HAZARD_PERF_CNT_EN
    check("mw_stall_cycles", stall_cycles, 32'd3);
`endif

    // Timeout boundary: 15 waits stay clean, 16 set the sticky flag.
    hz.dmem_ready = 0;
    for (int i = 0; i < MEM_TIMEOUT - 1; i++) cycle();
    hz.dmem_ready = 1;
    cycle();
    check("to_15", hz.mem_timeout, 1'b0);
    hz.dmem_ready = 0;
    for (int i = 0; i < MEM_TIMEOUT; i++) cycle();
    #1 check("to_16", hz.mem_timeout, 1'b1);
    hz.dmem_ready = 1;
    cycle();

    // Halt, random activity while frozen, then reset out of it.
    clear_inputs();
    hz.halt_req = 1;
    cycle();
    for (int i = 0; i < 4; i++) begin
      random_inputs();
      #1 check("halt_frozen", {hz.halted, hz.pc_write, hz.if_id_write, hz.forward_a}, 5'b10000);
      cycle();
    end
    apply_reset();
    clear_inputs();
    #1 check("post_halt_run", {hz.halted, hz.pc_write}, 2'b01);
    cycle();

    // Randomized traffic against the model.
    halt_run = 0;
    for (int i = 0; i < 1500; i++) begin
      if (m_halted) halt_run++; else halt_run = 0;
      if (halt_run > 3 || $urandom_range(0, 199) == 0) begin
        apply_reset();
        halt_run = 0;
      end
      random_inputs();
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
